// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle RV32 sequencing controller:
// states, opcodes, ALU ops, datapath mux selects and trap causes.
package multicycle_control_fsm_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRd,
        StMemWb,
        StMemWr,
        StExecR,
        StAluWb,
        StTrap
    } state_e;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_OR      = 3'b110;

    typedef enum logic [1:0] {
        AluAdd = 2'b00,
        AluSub = 2'b01,
        AluAnd = 2'b10,
        AluOr  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        SrcAPc  = 2'b00,
        SrcAReg = 2'b01
    } src_a_e;

    typedef enum logic [1:0] {
        SrcBReg  = 2'b00,
        SrcBImm  = 2'b01,
        SrcBFour = 2'b10
    } src_b_e;

    typedef enum logic [1:0] {
        ResAluOut = 2'b00,
        ResData   = 2'b01,
        ResAluRes = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        CauseNone       = 2'b00,
        CauseBadOpcode  = 2'b01,
        CauseBadFunct   = 2'b10,
        CauseMemTimeout = 2'b11
    } trap_cause_e;

    // States that hold a memory request open until mem_ready.
    function automatic logic is_wait_state(state_e s);
        return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bus between the multicycle sequencer (master) and the datapath/memory (slave).
interface multicycle_control_fsm_if;

    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       mem_ready;

    logic       Mem_Req;
    logic       Adr_Src;
    logic       DM_WE;
    logic       IR_WE;
    logic       PC_WE;
    logic       RF_WE;
    logic       Extend_Src;
    logic [1:0] AluSrcA;
    logic [1:0] AluSrcB;
    logic [1:0] Alu_control;
    logic [1:0] ResultSrc;

    modport master (
        input  opcode, func3, func7, mem_ready,
        output Mem_Req, Adr_Src, DM_WE, IR_WE, PC_WE, RF_WE, Extend_Src,
        output AluSrcA, AluSrcB, Alu_control, ResultSrc
    );

    modport slave (
        output opcode, func3, func7, mem_ready,
        input  Mem_Req, Adr_Src, DM_WE, IR_WE, PC_WE, RF_WE, Extend_Src,
        input  AluSrcA, AluSrcB, Alu_control, ResultSrc
    );

endinterface

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// R-type {func7,func3} to ALU operation decode; shared with the single-cycle control unit.
module multicycle_control_fsm_alu_decoder
    import multicycle_control_fsm_pkg::*;
(
    input  logic [6:0] func7_i,
    input  logic [2:0] func3_i,
    output alu_op_e    alu_op_o,
    output logic       illegal_o
);

    always_comb begin
        alu_op_o  = AluAdd;
        illegal_o = 1'b0;
        unique case ({func7_i, func3_i})
            {F7_BASE, F3_ADD_SUB}: alu_op_o = AluAdd;
            {F7_ALT,  F3_ADD_SUB}: alu_op_o = AluSub;
            {F7_BASE, F3_AND}:     alu_op_o = AluAnd;
            {F7_BASE, F3_OR}:      alu_op_o = AluOr;
            default:               illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32 sequencer: fetch/decode/execute/memory/writeback with a shared memory
// port, memory-stall timeout, sticky trap and retired-instruction counter.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    multicycle_control_fsm_if.master ctl,
    output logic                     trap,
    output logic [1:0]               trap_cause,
    output logic [CNT_W-1:0]         instr_retired
);

    localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WaitW-1:0] WaitLast =
        (MEM_TIMEOUT == 0) ? '0 : WaitW'(MEM_TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               trap_q, trap_d;
    trap_cause_e        cause_q, cause_d;

    alu_op_e            dec_op;
    logic               dec_illegal;

    logic               mem_req, adr_src, dm_we, ir_we, pc_we, rf_we, ext_src;
    src_a_e             src_a;
    src_b_e             src_b;
    alu_op_e            alu_ctl;
    result_src_e        result_src;
    logic               retire;
    logic               timeout_hit;

    multicycle_control_fsm_alu_decoder u_alu_decoder (
        .func7_i   (ctl.func7),
        .func3_i   (ctl.func3),
        .alu_op_o  (dec_op),
        .illegal_o (dec_illegal)
    );

    // A completing access in the last allowed wait cycle takes priority over the trap.
    assign timeout_hit = (MEM_TIMEOUT != 0) && !ctl.mem_ready && (wait_q == WaitLast);

    always_comb begin
        state_d    = state_q;
        trap_d     = trap_q;
        cause_d    = cause_q;
        retire     = 1'b0;
        mem_req    = 1'b0;
        adr_src    = 1'b0;
        dm_we      = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        rf_we      = 1'b0;
        ext_src    = 1'b0;
        src_a      = SrcAPc;
        src_b      = SrcBReg;
        alu_ctl    = AluAdd;
        result_src = ResAluOut;

        unique case (state_q)
            StFetch: begin
                mem_req    = 1'b1;
                src_b      = SrcBFour;
                result_src = ResAluRes;
                if (ctl.mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = StDecode;
                end else if (timeout_hit) begin
                    state_d = StTrap;
                    trap_d  = 1'b1;
                    cause_d = CauseMemTimeout;
                end
            end
            StDecode: begin
                if (ctl.opcode == OP_LOAD || ctl.opcode == OP_STORE) begin
                    state_d = StMemAdr;
                end else if (ctl.opcode == OP_RTYPE) begin
                    state_d = StExecR;
                end else begin
                    state_d = StTrap;
                    trap_d  = 1'b1;
                    cause_d = CauseBadOpcode;
                end
            end
            StMemAdr: begin
                src_a   = SrcAReg;
                src_b   = SrcBImm;
                ext_src = (ctl.opcode == OP_STORE);
                state_d = (ctl.opcode == OP_LOAD) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (ctl.mem_ready) begin
                    state_d = StMemWb;
                end else if (timeout_hit) begin
                    state_d = StTrap;
                    trap_d  = 1'b1;
                    cause_d = CauseMemTimeout;
                end
            end
            StMemWb: begin
                result_src = ResData;
                rf_we      = 1'b1;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                dm_we   = 1'b1;
                if (ctl.mem_ready) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end else if (timeout_hit) begin
                    state_d = StTrap;
                    trap_d  = 1'b1;
                    cause_d = CauseMemTimeout;
                end
            end
            StExecR: begin
                src_a   = SrcAReg;
                src_b   = SrcBReg;
                alu_ctl = dec_op;
                if (dec_illegal) begin
                    state_d = StTrap;
                    trap_d  = 1'b1;
                    cause_d = CauseBadFunct;
                end else begin
                    state_d = StAluWb;
                end
            end
            StAluWb: begin
                result_src = ResAluOut;
                rf_we      = 1'b1;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        // Reset wins over everything: no request, no write, nothing retires.
        if (rst) begin
            mem_req    = 1'b0;
            adr_src    = 1'b0;
            dm_we      = 1'b0;
            ir_we      = 1'b0;
            pc_we      = 1'b0;
            rf_we      = 1'b0;
            ext_src    = 1'b0;
            src_a      = SrcAPc;
            src_b      = SrcBReg;
            alu_ctl    = AluAdd;
            result_src = ResAluOut;
            retire     = 1'b0;
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (is_wait_state(state_q) && !ctl.mem_ready) begin
            wait_d = wait_q + WaitW'(1);
        end
    end

    assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            wait_q    <= '0;
            retired_q <= '0;
            trap_q    <= 1'b0;
            cause_q   <= CauseNone;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            trap_q    <= trap_d;
            cause_q   <= cause_d;
        end
    end

    assign ctl.Mem_Req     = mem_req;
    assign ctl.Adr_Src     = adr_src;
    assign ctl.DM_WE       = dm_we;
    assign ctl.IR_WE       = ir_we;
    assign ctl.PC_WE       = pc_we;
    assign ctl.RF_WE       = rf_we;
    assign ctl.Extend_Src  = ext_src;
    assign ctl.AluSrcA     = src_a;
    assign ctl.AluSrcB     = src_b;
    assign ctl.Alu_control = alu_ctl;
    assign ctl.ResultSrc   = result_src;

    assign trap          = trap_q;
    assign trap_cause    = cause_q;
    assign instr_retired = retired_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Cycle-by-cycle vector bench for the multicycle sequencer; expected control words
// are queued as each cycle is driven and compared half a cycle later.
module tb_multicycle_control_fsm;

    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CW      = 4;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    typedef struct packed {
        logic       mem_req;
        logic       adr_src;
        logic       dm_we;
        logic       ir_we;
        logic       pc_we;
        logic       rf_we;
        logic       ext;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] alu;
        logic [1:0] res;
    } ctl_t;

    typedef struct {
        string       tag;
        logic        rst;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        rdy;
        ctl_t        ctl;
        logic        trap;
        logic [1:0]  cause;
        logic [CW-1:0] ret;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          trap;
    logic [1:0]    trap_cause;
    logic [CW-1:0] instr_retired;

    multicycle_control_fsm_if cif ();

    multicycle_control_fsm #(
        .MEM_TIMEOUT (TIMEOUT),
        .CNT_W       (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ctl           (cif),
        .trap          (trap),
        .trap_cause    (trap_cause),
        .instr_retired (instr_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    logic          exp_trap;
    logic [1:0]    exp_cause;
    logic [CW-1:0] exp_ret;

    ctl_t c_zero, c_fetch_w, c_fetch_g, c_adr_lw, c_adr_sw, c_mem_rd, c_mem_wb, c_mem_wr;
    ctl_t c_alu_wb;

    function automatic ctl_t mk(input logic mreq, input logic adr, input logic dwe,
                                input logic irwe, input logic pcwe, input logic rfwe,
                                input logic ext, input logic [1:0] a, input logic [1:0] b,
                                input logic [1:0] alu, input logic [1:0] res);
        return {mreq, adr, dwe, irwe, pcwe, rfwe, ext, a, b, alu, res};
    endfunction

    function automatic ctl_t c_exec(input logic [1:0] alu);
        return mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, alu, 2'b00);
    endfunction

    task automatic v(input string tag, input logic r, input logic [6:0] op,
                     input logic [2:0] f3, input logic [6:0] f7, input logic rdy,
                     input ctl_t c);
        vec_t x;
        x.tag = tag; x.rst = r; x.op = op; x.f3 = f3; x.f7 = f7; x.rdy = rdy;
        x.ctl = c; x.trap = exp_trap; x.cause = exp_cause; x.ret = exp_ret;
        vecs.push_back(x);
    endtask

    task automatic do_reset(input string tag, input logic rdy);
        v(tag, 1'b1, OP_R, 3'b000, 7'b0, rdy, c_zero);
        exp_trap = 1'b0; exp_cause = 2'b00; exp_ret = '0;
    endtask

    task automatic r_instr(input string tag, input logic [6:0] f7, input logic [2:0] f3,
                           input logic [1:0] alu);
        v({tag, ".fetch"}, 0, OP_R, f3, f7, 1, c_fetch_g);
        v({tag, ".decode"}, 0, OP_R, f3, f7, 1, c_zero);
        v({tag, ".exec"}, 0, OP_R, f3, f7, 1, c_exec(alu));
        v({tag, ".wb"}, 0, OP_R, f3, f7, 1, c_alu_wb);
        exp_ret = exp_ret + 1'b1;
    endtask

    task automatic lw_instr(input string tag, input int fw, input int rw);
        for (int i = 0; i < fw; i++) v({tag, ".fwait"}, 0, OP_LW, 3'b010, 7'b0, 0, c_fetch_w);
        v({tag, ".fetch"}, 0, OP_LW, 3'b010, 7'b0, 1, c_fetch_g);
        v({tag, ".decode"}, 0, OP_LW, 3'b010, 7'b0, 1, c_zero);
        v({tag, ".adr"}, 0, OP_LW, 3'b010, 7'b0, 1, c_adr_lw);
        for (int i = 0; i < rw; i++) v({tag, ".rwait"}, 0, OP_LW, 3'b010, 7'b0, 0, c_mem_rd);
        v({tag, ".rd"}, 0, OP_LW, 3'b010, 7'b0, 1, c_mem_rd);
        v({tag, ".wb"}, 0, OP_LW, 3'b010, 7'b0, 1, c_mem_wb);
        exp_ret = exp_ret + 1'b1;
    endtask

    task automatic sw_instr(input string tag, input int ww);
        v({tag, ".fetch"}, 0, OP_SW, 3'b010, 7'b0, 1, c_fetch_g);
        v({tag, ".decode"}, 0, OP_SW, 3'b010, 7'b0, 1, c_zero);
        v({tag, ".adr"}, 0, OP_SW, 3'b010, 7'b0, 1, c_adr_sw);
        for (int i = 0; i < ww; i++) v({tag, ".wwait"}, 0, OP_SW, 3'b010, 7'b0, 0, c_mem_wr);
        v({tag, ".wr"}, 0, OP_SW, 3'b010, 7'b0, 1, c_mem_wr);
        exp_ret = exp_ret + 1'b1;
    endtask

    task automatic trap_hold(input string tag, input int n);
        for (int i = 0; i < n; i++) v(tag, 0, OP_R, 3'b000, 7'b0, i[0], c_zero);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            vec_t e;
            ctl_t act;
            e = sb.pop_front();
            act = {cif.Mem_Req, cif.Adr_Src, cif.DM_WE, cif.IR_WE, cif.PC_WE, cif.RF_WE,
                   cif.Extend_Src, cif.AluSrcA, cif.AluSrcB, cif.Alu_control, cif.ResultSrc};
            n_vec++;
            if (act !== e.ctl || trap !== e.trap || trap_cause !== e.cause ||
                instr_retired !== e.ret) begin
                n_bad++;
                $display("FAIL %s (vec %0d): got ctl=%h trap=%b cause=%b ret=%0d, want ctl=%h trap=%b cause=%b ret=%0d",
                         e.tag, n_vec - 1, act, trap, trap_cause, instr_retired,
                         e.ctl, e.trap, e.cause, e.ret);
            end
        end
    end

    initial begin
        rst = 1'b1;
        cif.opcode = '0; cif.func3 = '0; cif.func7 = '0; cif.mem_ready = 1'b0;
        exp_trap = 1'b0; exp_cause = 2'b00; exp_ret = '0;

        c_zero    = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        c_fetch_w = mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10);
        c_fetch_g = mk(1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10);
        c_adr_lw  = mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00);
        c_adr_sw  = mk(0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b01, 2'b00, 2'b00);
        c_mem_rd  = mk(1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        c_mem_wb  = mk(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01);
        c_mem_wr  = mk(1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        c_alu_wb  = mk(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00);

        do_reset("reset0", 0);
        do_reset("reset1", 1);
        r_instr("add", 7'b0000000, 3'b000, 2'b00);
        r_instr("sub", 7'b0100000, 3'b000, 2'b01);
        r_instr("and", 7'b0000000, 3'b111, 2'b10);
        r_instr("or",  7'b0000000, 3'b110, 2'b11);
        lw_instr("lw_rwait3", 0, 3);
        lw_instr("lw_fwait3_rwait3", 3, 3);
        sw_instr("sw", 0);
        sw_instr("sw_wwait2", 2);

        // Unsupported opcode: absorbing trap until reset.
        v("badop.fetch", 0, OP_IMM, 3'b000, 7'b0, 1, c_fetch_g);
        v("badop.decode", 0, OP_IMM, 3'b000, 7'b0, 1, c_zero);
        exp_trap = 1'b1; exp_cause = 2'b01;
        trap_hold("badop.trap", 11);
        do_reset("badop.rst", 1);

        v("mul.fetch", 0, OP_R, 3'b000, 7'b0000001, 1, c_fetch_g);
        v("mul.decode", 0, OP_R, 3'b000, 7'b0000001, 1, c_zero);
        v("mul.exec", 0, OP_R, 3'b000, 7'b0000001, 1, c_exec(2'b00));
        exp_trap = 1'b1; exp_cause = 2'b10;
        trap_hold("mul.trap", 3);
        do_reset("mul.rst", 0);

        for (int i = 0; i < int'(TIMEOUT); i++) v("fto.wait", 0, OP_R, 3'b000, 7'b0, 0, c_fetch_w);
        exp_trap = 1'b1; exp_cause = 2'b11;
        trap_hold("fto.trap", 3);
        do_reset("fto.rst", 0);

        // Ready arrives on the last allowed wait cycle: completes normally.
        lw_instr("fto_edge", int'(TIMEOUT) - 1, 0);

        v("wto.fetch", 0, OP_SW, 3'b010, 7'b0, 1, c_fetch_g);
        v("wto.decode", 0, OP_SW, 3'b010, 7'b0, 1, c_zero);
        v("wto.adr", 0, OP_SW, 3'b010, 7'b0, 1, c_adr_sw);
        for (int i = 0; i < int'(TIMEOUT); i++) v("wto.wait", 0, OP_SW, 3'b010, 7'b0, 0, c_mem_wr);
        exp_trap = 1'b1; exp_cause = 2'b11;
        trap_hold("wto.trap", 2);
        do_reset("wto.rst", 0);

        // Reset during a pending store: write not completed, nothing retires.
        r_instr("pre", 7'b0000000, 3'b000, 2'b00);
        v("midrst.fetch", 0, OP_SW, 3'b010, 7'b0, 1, c_fetch_g);
        v("midrst.decode", 0, OP_SW, 3'b010, 7'b0, 1, c_zero);
        v("midrst.adr", 0, OP_SW, 3'b010, 7'b0, 1, c_adr_sw);
        v("midrst.wwait", 0, OP_SW, 3'b010, 7'b0, 0, c_mem_wr);
        do_reset("midrst.rst", 1);

        // Retire counter wrap at 2^CW.
        for (int i = 0; i < (1 << CW) + 1; i++) r_instr("wrap", 7'b0000000, 3'b000, 2'b00);
        v("wrap.end", 0, OP_R, 3'b000, 7'b0, 0, c_fetch_w);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            rst           = vecs[i].rst;
            cif.opcode    = vecs[i].op;
            cif.func3     = vecs[i].f3;
            cif.func7     = vecs[i].f7;
            cif.mem_ready = vecs[i].rdy;
            sb.push_back(vecs[i]);
        end
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
